cheri_data_mem_responder: RTL and testbench

// - Responder (memory side) of the core data interface: req/gnt/rvalid handshake, 33-bit data

---
 rtl/cheri_dmem_pkg.sv | 28 ++
 rtl/cheri_dmem_resp_pipe.sv | 47 ++++
 rtl/cheri_data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_cheri_data_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheri_dmem_pkg.sv
// cheri_dmem_pkg: shared types and helpers for the CHERI data-memory responder.
//   dmem_resp_t     : one response-pipe entry {valid, rdata (bit 32 = tag), err}
//   DMEM_TAG_BIT    : position of the capability tag in the 33-bit data word
//   DMEM_LFSR_SEED  : reset value of the optional random-stall LFSR
//   addr_in_range() : word-aligned window check of a byte address
package cheri_dmem_pkg;

  localparam int          DMEM_TAG_BIT   = 32;
  localparam logic [15:0] DMEM_LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic        valid;
    logic [32:0] rdata;
    logic        err;
  } dmem_resp_t;

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [32:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(words) << 2);
    return (a >= lo) && (a < hi) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cheri_dmem_resp_pipe.sv
// cheri_dmem_resp_pipe: fixed-latency response shift pipe, no backpressure.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears every stage)
//   resp_i        : entry captured at this clock edge (valid = grant this cycle)
//   resp_o        : entry leaving the pipe STAGES cycles after capture
// Data fields only move along with a valid bit, so the last stage keeps the
// most recent response data while no new response is emerging.
module cheri_dmem_resp_pipe
  import cheri_dmem_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  dmem_resp_t resp_i,
  output dmem_resp_t resp_o
);

  logic [STAGES:1]       vld_pipe;
  logic [STAGES:1][32:0] rdata_pipe;
  logic [STAGES:1]       err_pipe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe   <= '0;
      rdata_pipe <= '0;
      err_pipe   <= '0;
    end else begin
      vld_pipe[1] <= resp_i.valid;
      if (resp_i.valid) begin
        rdata_pipe[1] <= resp_i.rdata;
        err_pipe[1]   <= resp_i.err;
      end
      for (int s = 2; s <= int'(STAGES); s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          rdata_pipe[s] <= rdata_pipe[s-1];
          err_pipe[s]   <= err_pipe[s-1];
        end
      end
    end
  end

  assign resp_o.valid = vld_pipe[STAGES];
  assign resp_o.rdata = rdata_pipe[STAGES];
  assign resp_o.err   = err_pipe[STAGES];

endmodule

// File: rtl/cheri_data_mem_responder.sv
// cheri_data_mem_responder: memory-side responder for the core data interface.
//   Single-port word RAM with a per-word capability tag, configurable grant
//   delay, fixed response latency and a cap on outstanding requests.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   data_req_i             : request, attributes stable until gnt
//   data_is_cap_i          : capability access (tag written / returned)
//   data_we_i, data_be_i   : write enable, byte enables
//   data_addr_i            : byte address
//   data_wdata_i           : write data, bit 32 = tag
//   data_gnt_o             : request accepted this cycle (combinational)
//   data_rvalid_o          : one in-order response per grant
//   data_rdata_o           : read data, bit 32 = tag (0 for writes / errors)
//   data_err_o             : bus error, qualified by rvalid
// Build option: CHERI_DMEM_RAND_STALL_EN adds an LFSR that randomly withholds gnt.
module cheri_data_mem_responder
  import cheri_dmem_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h2000_0000,
  parameter int unsigned MemWords       = 4096,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_is_cap_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned AW = (MemWords > 1) ? $clog2(MemWords) : 1;

  logic [1:0]    cnt;
  logic [2:0]    outstanding;
  logic          stall;
  logic          slot_free;
  logic          gnt;
  logic          rvalid;
  logic          addr_ok;
  logic          wr_en;
  logic [AW-1:0] idx;
  dmem_resp_t    resp_in;
  dmem_resp_t    resp_out;

  logic [31:0]         mem [MemWords];
  logic [MemWords-1:0] tags;

  // ---------------- optional random stall ----------------
`ifdef CHERI_DMEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16/14/13/11.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= DMEM_LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------- grant ----------------
  // A response retiring this cycle frees its slot for a grant in the same cycle.
  assign slot_free = (outstanding < 3'(MaxOutstanding)) || rvalid;
  assign gnt       = data_req_i && (cnt == 2'(GntDelay)) && slot_free && !stall;

  // cnt saturates at GntDelay, so it waits there while stalled or slot-limited.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (!data_req_i || gnt) begin
      cnt <= '0;
    end else if (cnt < 2'(GntDelay)) begin
      cnt <= cnt + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({gnt, rvalid})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ---------------- array access at the grant edge ----------------
  assign addr_ok = addr_in_range(data_addr_i, MemBase, MemWords);
  assign idx     = AW'((data_addr_i - MemBase) >> 2);
  assign wr_en   = gnt && data_we_i && addr_ok && (data_be_i != 4'h0);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Any non-capability write that touches the word strips its tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tags <= '0;
    end else if (wr_en) begin
      tags[idx] <= data_is_cap_i && data_wdata_i[DMEM_TAG_BIT];
    end
  end

  always_comb begin
    resp_in       = '0;
    resp_in.valid = gnt;
    resp_in.err   = !addr_ok;
    if (addr_ok && !data_we_i) begin
      resp_in.rdata = {tags[idx] && data_is_cap_i, mem[idx]};
    end
  end

  // ---------------- response pipe ----------------
  cheri_dmem_resp_pipe #(
    .STAGES (RespLatency)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );

  assign rvalid        = resp_out.valid;
  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid;
  assign data_rdata_o  = resp_out.rdata;
  assign data_err_o    = resp_out.err;

endmodule

// File: tb/tb_cheri_data_mem_responder.sv
// Directed bench for cheri_data_mem_responder. Four instances cover the
// parameter sets of interest:
//   u0 : defaults (GntDelay 0, RespLatency 1, MaxOutstanding 2, 4096 words)
//   u1 : RespLatency 4, MaxOutstanding 2
//   u2 : GntDelay 2, RespLatency 3
//   u3 : RespLatency 3 (mid-operation reset)
module tb_cheri_data_mem_responder;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [4];
  logic        is_cap [4];
  logic        we     [4];
  logic [3:0]  be     [4];
  logic [31:0] addr   [4];
  logic [32:0] wdata  [4];
  logic        gnt    [4];
  logic        rvalid [4];
  logic [32:0] rdata  [4];
  logic        err    [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cheri_data_mem_responder #(.MemBase(BASE)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_is_cap_i(is_cap[0]),
    .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

  cheri_data_mem_responder #(.MemBase(BASE), .MemWords(16), .RespLatency(4), .MaxOutstanding(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_is_cap_i(is_cap[1]),
    .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

  cheri_data_mem_responder #(.MemBase(BASE), .MemWords(16), .GntDelay(2), .RespLatency(3)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_is_cap_i(is_cap[2]),
    .data_we_i(we[2]), .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
    .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

  cheri_data_mem_responder #(.MemBase(BASE), .MemWords(16), .RespLatency(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[3]), .data_is_cap_i(is_cap[3]),
    .data_we_i(we[3]), .data_be_i(be[3]), .data_addr_i(addr[3]), .data_wdata_i(wdata[3]),
    .data_gnt_o(gnt[3]), .data_rvalid_o(rvalid[3]), .data_rdata_o(rdata[3]), .data_err_o(err[3]));

  // One complete transaction on instance d; returns the response. Called and
  // returns just after a rising edge. Both waits are bounded.
  task automatic access(input int d, input logic w, input logic c, input logic [3:0] b,
                        input logic [31:0] a, input logic [32:0] wd,
                        output logic [32:0] rd, output logic e);
    bit got;
    int n;
    req[d] = 1'b1; we[d] = w; is_cap[d] = c; be[d] = b; addr[d] = a; wdata[d] = wd;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk); got = gnt[d];
      @(posedge clk); #1; n++;
    end
    req[d] = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL access_gnt_timeout u%0d: gnt=0 required=1", d); end
    got = 1'b0; n = 0; rd = 'x; e = 'x;
    while (!got && n < 20) begin
      @(negedge clk);
      if (rvalid[d] === 1'b1) begin got = 1'b1; rd = rdata[d]; e = err[d]; end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL access_rvalid_timeout u%0d: rvalid=0 required=1", d); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      req[d] = 0; is_cap[d] = 0; we[d] = 0; be[d] = 0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({gnt[d], rvalid[d], err[d], rdata[d]} !== 36'h0) begin
        errors++;
        $display("FAIL reset_outputs u%0d: gnt=%b rvalid=%b err=%b rdata=%h required all 0",
                 d, gnt[d], rvalid[d], err[d], rdata[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    req[0] = 1; we[0] = 1; is_cap[0] = 0; be[0] = 4'hF; addr[0] = BASE; wdata[0] = 33'h0_1234_5678;
    @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b1) begin errors++; $display("FAIL basic_wr_gnt: gnt=%b required=1", gnt[0]); end
    @(posedge clk); #1;
    we[0] = 0;
    @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b1) begin errors++; $display("FAIL basic_rd_gnt: gnt=%b required=1", gnt[0]); end
    checks++;
    if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b0, 33'h0}) begin
      errors++;
      $display("FAIL basic_wr_resp: rvalid=%b err=%b rdata=%h required 1 0 000000000", rvalid[0], err[0], rdata[0]);
    end
    @(posedge clk); #1;
    req[0] = 0;
    @(negedge clk);
    checks++;
    if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b0, 33'h0_1234_5678}) begin
      errors++;
      $display("FAIL basic_rd_resp: rvalid=%b err=%b rdata=%h required 1 0 012345678", rvalid[0], err[0], rdata[0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rvalid[0], rdata[0]} !== {1'b0, 33'h0_1234_5678}) begin
      errors++;
      $display("FAIL basic_hold: rvalid=%b rdata=%h required 0 012345678", rvalid[0], rdata[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tag();
    logic [32:0] rd;
    logic        e;
    access(0, 1, 1, 4'hF, BASE, 33'h1_DEAD_BEEF, rd, e);
    checks++;
    if ({e, rd} !== 34'h0) begin errors++; $display("FAIL tag_wr_resp: err=%b rdata=%h required 0 000000000", e, rd); end
    access(0, 0, 1, 4'hF, BASE, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b0, 33'h1_DEAD_BEEF}) begin errors++; $display("FAIL tag_cap_rd: err=%b rdata=%h required 0 1deadbeef", e, rd); end
    access(0, 1, 0, 4'b0001, BASE, 33'h0_0000_00AA, rd, e);
    access(0, 0, 1, 4'hF, BASE, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b0, 33'h0_DEAD_BEAA}) begin errors++; $display("FAIL tag_byte_wr: err=%b rdata=%h required 0 0deadbeaa", e, rd); end
    access(0, 1, 1, 4'hF, BASE + 32'd4, 33'h1_5555_AAAA, rd, e);
    access(0, 0, 0, 4'hF, BASE + 32'd4, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b0, 33'h0_5555_AAAA}) begin errors++; $display("FAIL tag_noncap_rd: err=%b rdata=%h required 0 05555aaaa", e, rd); end
    access(0, 1, 0, 4'h0, BASE + 32'd4, 33'h0_FFFF_FFFF, rd, e);
    checks++;
    if ({e, rd} !== 34'h0) begin errors++; $display("FAIL tag_be0_resp: err=%b rdata=%h required 0 000000000", e, rd); end
    access(0, 0, 1, 4'hF, BASE + 32'd4, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b0, 33'h1_5555_AAAA}) begin errors++; $display("FAIL tag_be0_nochange: err=%b rdata=%h required 0 15555aaaa", e, rd); end
  endtask

  task automatic test_err();
    logic [32:0] rd;
    logic        e;
    access(0, 0, 1, 4'hF, BASE + 32'h4000, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b1, 33'h0}) begin errors++; $display("FAIL err_rd_top: err=%b rdata=%h required 1 000000000", e, rd); end
    access(0, 1, 1, 4'hF, BASE + 32'h4000, 33'h1_1111_1111, rd, e);
    checks++;
    if ({e, rd} !== {1'b1, 33'h0}) begin errors++; $display("FAIL err_wr_top: err=%b rdata=%h required 1 000000000", e, rd); end
    access(0, 1, 1, 4'hF, BASE + 32'd1, 33'h1_2222_2222, rd, e);
    checks++;
    if ({e, rd} !== {1'b1, 33'h0}) begin errors++; $display("FAIL err_wr_misaligned: err=%b rdata=%h required 1 000000000", e, rd); end
    access(0, 0, 0, 4'hF, BASE + 32'd1, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b1, 33'h0}) begin errors++; $display("FAIL err_rd_misaligned: err=%b rdata=%h required 1 000000000", e, rd); end
    access(0, 0, 0, 4'hF, BASE - 32'd4, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b1, 33'h0}) begin errors++; $display("FAIL err_rd_below: err=%b rdata=%h required 1 000000000", e, rd); end
    access(0, 0, 1, 4'hF, BASE, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b0, 33'h0_DEAD_BEAA}) begin errors++; $display("FAIL err_base_unchanged: err=%b rdata=%h required 0 0deadbeaa", e, rd); end
  endtask

  // u1: RespLatency 4, MaxOutstanding 2; reads held from cycle 0 to 4.
  task automatic test_back_to_back();
    logic [32:0] rd;
    logic        e;
    logic [9:0]  eg;
    logic [9:0]  er;
    logic [32:0] ed [3];
    int          k;
    access(1, 1, 0, 4'hF, BASE,          33'h0_0000_0111, rd, e);
    access(1, 1, 0, 4'hF, BASE + 32'd4,  33'h0_0000_0222, rd, e);
    access(1, 1, 0, 4'hF, BASE + 32'd8,  33'h0_0000_0333, rd, e);
    eg = 10'h013;
    er = 10'h130;
    ed[0] = 33'h0_0000_0111; ed[1] = 33'h0_0000_0222; ed[2] = 33'h0_0000_0333;
    k = 0;
    we[1] = 0; is_cap[1] = 0; be[1] = 4'hF;
    for (int c = 0; c < 10; c++) begin
      req[1]  = (c <= 4);
      addr[1] = BASE + 32'(4 * ((c < 2) ? c : 2));
      @(negedge clk);
      checks++;
      if (gnt[1] !== eg[c]) begin errors++; $display("FAIL b2b_gnt cycle %0d: gnt=%b required=%b", c, gnt[1], eg[c]); end
      checks++;
      if (rvalid[1] !== er[c]) begin errors++; $display("FAIL b2b_rvalid cycle %0d: rvalid=%b required=%b", c, rvalid[1], er[c]); end
      if (er[c] && k < 3) begin
        checks++;
        if ({err[1], rdata[1]} !== {1'b0, ed[k]}) begin
          errors++; $display("FAIL b2b_rdata %0d: err=%b rdata=%h required 0 %h", k, err[1], rdata[1], ed[k]);
        end
        k++;
      end
      if (c == 6) begin
        checks++;
        if (rdata[1] !== 33'h0_0000_0222) begin errors++; $display("FAIL b2b_hold: rdata=%h required 000000222", rdata[1]); end
      end
      @(posedge clk); #1;
    end
    req[1] = 0;
  endtask

  // u2: GntDelay 2.
  task automatic test_gnt_delay();
    logic [9:0] rq;
    logic [9:0] eg;
    rq = 10'b01_1101_0111;
    eg = 10'b01_0000_0100;
    we[2] = 0; is_cap[2] = 0; be[2] = 4'hF; addr[2] = BASE;
    for (int c = 0; c < 10; c++) begin
      req[2] = rq[c];
      @(negedge clk);
      checks++;
      if (gnt[2] !== eg[c]) begin errors++; $display("FAIL gnt_delay cycle %0d: gnt=%b required=%b", c, gnt[2], eg[c]); end
      @(posedge clk); #1;
    end
    req[2] = 0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // u3: RespLatency 3; reset with two reads in flight.
  task automatic test_reset_mid();
    logic [32:0] rd;
    logic        e;
    int          seen;
    access(3, 1, 1, 4'hF, BASE, 33'h1_CAFE_F00D, rd, e);
    access(3, 0, 1, 4'hF, BASE, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b0, 33'h1_CAFE_F00D}) begin errors++; $display("FAIL rstmid_pre_rd: err=%b rdata=%h required 0 1cafef00d", e, rd); end
    req[3] = 1; we[3] = 0; is_cap[3] = 1; be[3] = 4'hF; addr[3] = BASE;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (gnt[3] !== 1'b1) begin errors++; $display("FAIL rstmid_inflight_gnt %0d: gnt=%b required=1", c, gnt[3]); end
      @(posedge clk); #1;
    end
    req[3] = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt[3], rvalid[3], err[3], rdata[3]} !== 36'h0) begin
      errors++; $display("FAIL rstmid_outputs: gnt=%b rvalid=%b err=%b rdata=%h required all 0", gnt[3], rvalid[3], err[3], rdata[3]);
    end
    checks++;
    if (rdata[0] !== 33'h0) begin errors++; $display("FAIL rstmid_u0_rdata: rdata=%h required 000000000", rdata[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid[3] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmid_no_rvalid: rvalid cycles=%0d required=0", seen); end
    req[3] = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (gnt[3] !== 1'b1) begin errors++; $display("FAIL rstmid_outstanding_cleared %0d: gnt=%b required=1", c, gnt[3]); end
      @(posedge clk); #1;
    end
    req[3] = 0;
    repeat (6) @(posedge clk);
    #1;
    access(3, 0, 1, 4'hF, BASE, 33'h0, rd, e);
    checks++;
    if ({e, rd} !== {1'b0, 33'h0_CAFE_F00D}) begin errors++; $display("FAIL rstmid_tag_cleared: err=%b rdata=%h required 0 0cafef00d", e, rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tag();
    test_err();
    test_back_to_back();
    test_gnt_delay();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
